disp_arbiter: RTL and testbench
===============================

Name: disp_arbiter

Overview:
- Round-robin arbiter/scheduler for the shared board display resource: the 8 water LEDs and both 9-bit segment digits (SPGFEDCBA).
- Up to N_REQ producer blocks (heart-beat counter, lightness demo, switch echo, …) each request the display and present their own pattern. The arbiter grants one owner at a time, enforces a minimum hold time counted in slow ticks, and inserts a blanking gap between owners.
- Sits between the producer blocks and the top-level output pins, ahead of the brightness gating.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- HOLD_TICKS, 3, minimum tick_in pulses an owner keeps the display before it can be preempted by a waiting requester (1..15).
- GAP_CYCLES, 12000, blanking cycles between owners (1 ms at 12 MHz; >=1).

Ports:
- clk_in, input, 1, system clock, 12 MHz.
- rst_in, input, 1, synchronous active-high reset.
- tick_in, input, 1, one-cycle slow pulse (e.g. 1 Hz divider pulse) used for hold counting.
- req_in, input, N_REQ, per-requester level request. Bit i belongs to requester i.
- led_data_in, input, 8*N_REQ, water-LED pattern per requester. Slice i is [8i+7:8i], active low.
- seg1_data_in, input, 9*N_REQ, digit-1 pattern per requester, slice [9i+8:9i].
- seg2_data_in, input, 9*N_REQ, digit-2 pattern per requester, slice [9i+8:9i].
- grant_out, output, N_REQ, one-hot grant (all zero when no owner).
- busy_out, output, 1, high when state is OWN or GAP.
- Water_led, output, 8, registered LED drive.
- Segment_led_1, output, 9, registered digit-1 drive.
- Segment_led_2, output, 9, registered digit-2 drive.

Behaviour:
- Blank values: Water_led = 8'hff, Segment_led_1/2 = 9'h000.
- Reset (synchronous, any state, mid-grant included):
  - state = IDLE, grant_out = 0, busy_out = 0, outputs blank.
  - hold_cnt = 0, gap_cnt = 0.
  - last_owner = N_REQ-1, so requester 0 wins first.
- Round-robin pick: search req_in starting at last_owner+1, modulo N_REQ. The first set bit wins. This is a pure function of req_in and last_owner.
- State IDLE:
  - Outputs blank, grant_out = 0.
  - If any req_in is set at cycle t: at t+1 state = OWN, grant_out = onehot(pick), last_owner = pick, hold_cnt = 0.
- State OWN:
  - Each cycle, the display outputs register the owner's slices, so they are one cycle behind the inputs. The first owner data appears at t+2 relative to the request.
  - hold_cnt increments on tick_in and saturates at HOLD_TICKS.
  - Owner deasserts req -> GAP next cycle, regardless of hold_cnt (voluntary release).
  - hold_cnt == HOLD_TICKS and any other req set -> GAP next cycle (preemption).
  - hold_cnt == HOLD_TICKS and no other req -> stay in OWN, counter saturated.
  - tick_in in the same cycle as owner release: release wins; the tick is ignored.
- State GAP:
  - grant_out = 0, outputs blank, gap_cnt counts 0..GAP_CYCLES-1.
  - On the last gap cycle: if any req is set -> OWN with a fresh pick (last_owner updated, hold_cnt = 0); otherwise -> IDLE.
  - Requests that change during GAP are sampled only on the final cycle.
- Ownership rules:
  - A requester never receives two consecutive grants while another requester is waiting.
  - A sole requester may be re-granted after its own GAP.
- Stable case: tick_in held low with a single requester -> that requester owns the display indefinitely.

Optional Feature:
- Macro: DISP_ARB_PRIO0_EN.
- Defined:
  - Requester 0 preempts in OWN after 0 holds: any owner != 0 moves to GAP the cycle after req_in[0] rises, ignoring hold_cnt.
  - The pick after GAP selects requester 0 whenever req_in[0] is set.
- Undefined: pure round-robin with HOLD_TICKS hold for all requesters.

Decomposition:
- Package disp_arb_pkg holds:
  - state enum {IDLE, OWN, GAP};
  - LED_OFF = 8'hff and SEG_OFF = 9'h000;
  - width helpers for hold_cnt (4 bits) and gap_cnt ($clog2(GAP_CYCLES)).
- One sub-module, rr_pick: combinational rotate-priority encoder (req, last_owner -> valid, index).

Test Plan:
- Reset then req_in=4'b0001, led slice0=8'h5a -> grant_out=0001 at t+1, Water_led=8'h5a at t+2, busy_out=1.
- req_in=4'b0011 held, requester 0 owning, 3 tick_in pulses -> GAP of 12000 cycles with Water_led=8'hff and grant 0, then grant_out=0010.
- Owner 1 drops req in the same cycle as tick_in with hold_cnt=1 -> GAP next cycle, then IDLE after 12000 cycles if no req; outputs blank.
- All 4 requesting continuously -> grant sequence 0,1,2,3,0; each owner holds exactly 3 ticks; never two consecutive grants to the same index.
- rst_in asserted mid-OWN (owner 2) -> next cycle grant_out=0, Water_led=8'hff, Segment_led_1/2=9'h000; after release with req_in=4'b1111 the first grant goes to 0.
- DISP_ARB_PRIO0_EN defined, owner 3 at hold_cnt=0, req_in[0] rises -> GAP next cycle, then grant_out=0001.

Source files
------------

// File: rtl/disp_arb_pkg.sv
// Shared types and constants for the display arbiter: FSM states, blank
// patterns and counter width helpers.
package disp_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

   // Water LEDs are active low, segments active high.
   localparam logic [7:0] LED_OFF = 8'hff;
   localparam logic [8:0] SEG_OFF = 9'h000;

   localparam int HOLD_W = 4;

   function automatic int gap_cnt_w(input int gap_cycles);
      return (gap_cycles > 1) ? $clog2(gap_cycles) : 1;
   endfunction

endpackage

// File: rtl/disp_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request strictly after last_owner,
// wrapping modulo N_REQ.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_owner,
   output logic             valid,
   output logic [IDX_W-1:0] index
);

   logic [IDX_W-1:0] cand [N_REQ];
   logic [N_REQ-1:0] hit;

   // cand[gi] is the requester examined at search distance gi+1.
   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_cand
         logic [IDX_W:0] sum;
         assign sum       = {1'b0, last_owner} + (IDX_W+1)'(gi + 1);
         assign cand[gi]  = (sum >= (IDX_W+1)'(N_REQ)) ?
                            IDX_W'(sum - (IDX_W+1)'(N_REQ)) : sum[IDX_W-1:0];
         assign hit[gi]   = req[cand[gi]];
      end
   endgenerate

   always_comb begin
      valid = |hit;
      index = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (hit[k]) begin
            index = cand[k];
         end
      end
   end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin owner of the water LEDs and both segment digits, with minimum
// hold in slow ticks and a blanking gap between owners. DISP_ARB_PRIO0_EN
// gives requester 0 immediate preemption and first pick after a gap.
module disp_arbiter
   import disp_arb_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int HOLD_TICKS = 3,
   parameter int GAP_CYCLES = 12000
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               tick_in,
   input  logic [N_REQ-1:0]   req_in,
   input  logic [8*N_REQ-1:0] led_data_in,
   input  logic [9*N_REQ-1:0] seg1_data_in,
   input  logic [9*N_REQ-1:0] seg2_data_in,
   output logic [N_REQ-1:0]   grant_out,
   output logic               busy_out,
   output logic [7:0]         Water_led,
   output logic [8:0]         Segment_led_1,
   output logic [8:0]         Segment_led_2
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int GAP_W = gap_cnt_w(GAP_CYCLES);

   arb_state_t        state_reg;
   logic [IDX_W-1:0]  last_owner_reg;
   logic [HOLD_W-1:0] hold_cnt_reg;
   logic [GAP_W-1:0]  gap_cnt_reg;
   logic [N_REQ-1:0]  grant_reg;
   logic              busy_reg;
   logic [7:0]        water_reg;
   logic [8:0]        seg1_reg;
   logic [8:0]        seg2_reg;

   logic [7:0] led_slice  [N_REQ];
   logic [8:0] seg1_slice [N_REQ];
   logic [8:0] seg2_slice [N_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_slice
         assign led_slice[gi]  = led_data_in[8*gi +: 8];
         assign seg1_slice[gi] = seg1_data_in[9*gi +: 9];
         assign seg2_slice[gi] = seg2_data_in[9*gi +: 9];
      end
   endgenerate

   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] gap_idx;
   logic             owner_req;
   logic             other_req;
   logic             hold_done;
   logic             prio_hit;
   logic             own_leave;
   logic             gap_last;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req        (req_in),
      .last_owner (last_owner_reg),
      .valid      (pick_valid),
      .index      (pick_idx)
   );

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // grant_reg is onehot(last_owner_reg) while owning, so it masks the owner.
   assign owner_req = req_in[last_owner_reg];
   assign other_req = |(req_in & ~grant_reg);
   assign hold_done = (hold_cnt_reg == HOLD_W'(HOLD_TICKS));
   assign gap_last  = (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1));

`ifdef DISP_ARB_PRIO0_EN
   assign prio_hit = req_in[0] && (last_owner_reg != '0);
   assign gap_idx  = req_in[0] ? '0 : pick_idx;
`else
   assign prio_hit = 1'b0;
   assign gap_idx  = pick_idx;
`endif

   // Release beats any tick in the same cycle: leaving never touches hold_cnt.
   assign own_leave = !owner_req || (hold_done && other_req) || prio_hit;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_reg      <= IDLE;
         last_owner_reg <= IDX_W'(N_REQ - 1);
         hold_cnt_reg   <= '0;
         gap_cnt_reg    <= '0;
         grant_reg      <= '0;
         busy_reg       <= 1'b0;
         water_reg      <= LED_OFF;
         seg1_reg       <= SEG_OFF;
         seg2_reg       <= SEG_OFF;
      end else begin
         case (state_reg)
            IDLE: begin
               water_reg <= LED_OFF;
               seg1_reg  <= SEG_OFF;
               seg2_reg  <= SEG_OFF;
               if (pick_valid) begin
                  state_reg      <= OWN;
                  grant_reg      <= onehot(pick_idx);
                  last_owner_reg <= pick_idx;
                  hold_cnt_reg   <= '0;
                  busy_reg       <= 1'b1;
               end
            end
            OWN: begin
               if (own_leave) begin
                  state_reg   <= GAP;
                  grant_reg   <= '0;
                  gap_cnt_reg <= '0;
                  water_reg   <= LED_OFF;
                  seg1_reg    <= SEG_OFF;
                  seg2_reg    <= SEG_OFF;
               end else begin
                  water_reg <= led_slice[last_owner_reg];
                  seg1_reg  <= seg1_slice[last_owner_reg];
                  seg2_reg  <= seg2_slice[last_owner_reg];
                  if (tick_in && !hold_done) begin
                     hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                  end
               end
            end
            GAP: begin
               water_reg <= LED_OFF;
               seg1_reg  <= SEG_OFF;
               seg2_reg  <= SEG_OFF;
               if (gap_last) begin
                  gap_cnt_reg <= '0;
                  if (pick_valid) begin
                     state_reg      <= OWN;
                     grant_reg      <= onehot(gap_idx);
                     last_owner_reg <= gap_idx;
                     hold_cnt_reg   <= '0;
                  end else begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
               end
            end
            default: begin
               state_reg <= IDLE;
               grant_reg <= '0;
               busy_reg  <= 1'b0;
               water_reg <= LED_OFF;
               seg1_reg  <= SEG_OFF;
               seg2_reg  <= SEG_OFF;
            end
         endcase
      end
   end

   assign grant_out     = grant_reg;
   assign busy_out      = busy_reg;
   assign Water_led     = water_reg;
   assign Segment_led_1 = seg1_reg;
   assign Segment_led_2 = seg2_reg;

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter: two instances (full 12000-cycle gap and a short gap)
// checked every cycle against a behavioural model plus directed literal checks.
`timescale 1ns/1ps
module tb_disp_arbiter;

   localparam int N      = 4;
   localparam int A_GAP  = 12000;
   localparam int A_HOLD = 3;
   localparam int B_GAP  = 7;
   localparam int B_HOLD = 3;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OWN  = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   typedef struct packed {
      logic        valid;
      logic [1:0]  st;
      logic [2:0]  owner;
      logic [3:0]  ticks;
      logic [15:0] gap_left;
      logic [3:0]  grant;
      logic        busy;
      logic [7:0]  led;
      logic [8:0]  s1;
      logic [8:0]  s2;
   } mdl_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_a, tick_a, rst_b, tick_b;
   logic [N-1:0]   req_a, req_b;
   logic [8*N-1:0] led_a, led_b;
   logic [9*N-1:0] s1a, s2a, s1b, s2b;
   logic [N-1:0]   grant_a, grant_b;
   logic           busy_a, busy_b;
   logic [7:0]     wl_a, wl_b;
   logic [8:0]     sg1_a, sg2_a, sg1_b, sg2_b;

   disp_arbiter #(.N_REQ(N), .HOLD_TICKS(A_HOLD), .GAP_CYCLES(A_GAP)) u_dut_a (
      .clk_in(clk), .rst_in(rst_a), .tick_in(tick_a), .req_in(req_a),
      .led_data_in(led_a), .seg1_data_in(s1a), .seg2_data_in(s2a),
      .grant_out(grant_a), .busy_out(busy_a), .Water_led(wl_a),
      .Segment_led_1(sg1_a), .Segment_led_2(sg2_a));

   disp_arbiter #(.N_REQ(N), .HOLD_TICKS(B_HOLD), .GAP_CYCLES(B_GAP)) u_dut_b (
      .clk_in(clk), .rst_in(rst_b), .tick_in(tick_b), .req_in(req_b),
      .led_data_in(led_b), .seg1_data_in(s1b), .seg2_data_in(s2b),
      .grant_out(grant_b), .busy_out(busy_b), .Water_led(wl_b),
      .Segment_led_1(sg1_b), .Segment_led_2(sg2_b));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // First requester found scanning forward from the one after last.
   function automatic int rr(input logic [3:0] req, input int last);
      int i;
      for (int k = 1; k <= N; k++) begin
         i = (last + k) % N;
         if (req[i]) return i;
      end
      return -1;
   endfunction

   function automatic int oh2i(input logic [3:0] g);
      for (int i = 0; i < N; i++) if (g[i]) return i;
      return -1;
   endfunction

   function automatic mdl_t step(input mdl_t s, input logic rst, input logic tick,
                                 input logic [3:0] req, input logic [31:0] led,
                                 input logic [35:0] s1, input logic [35:0] s2,
                                 input int gapc, input int holdc);
      mdl_t n;
      int   p;
      bit   leave;
      n = s;
      if (rst) begin
         n.valid = 1'b1; n.st = S_IDLE; n.owner = 3'(N - 1); n.ticks = 4'd0; n.gap_left = 16'd0;
      end else if (s.st == S_IDLE) begin
         p = rr(req, int'(s.owner));
         if (p >= 0) begin n.st = S_OWN; n.owner = 3'(p); n.ticks = 4'd0; end
      end else if (s.st == S_OWN) begin
         leave = !req[s.owner] ||
                 ((int'(s.ticks) >= holdc) && ((req & ~(4'b0001 << s.owner)) != 4'b0));
`ifdef DISP_ARB_PRIO0_EN
         if (s.owner != 3'd0 && req[0]) leave = 1'b1;
`endif
         if (leave) begin
            n.st = S_GAP; n.gap_left = 16'(gapc);
         end else if (tick && int'(s.ticks) < holdc) begin
            n.ticks = s.ticks + 4'd1;
         end
      end else begin
         if (s.gap_left == 16'd1) begin
            p = rr(req, int'(s.owner));
`ifdef DISP_ARB_PRIO0_EN
            if (req[0]) p = 0;
`endif
            if (p >= 0) begin n.st = S_OWN; n.owner = 3'(p); n.ticks = 4'd0; end
            else n.st = S_IDLE;
         end else begin
            n.gap_left = s.gap_left - 16'd1;
         end
      end
      n.grant = (n.st == S_OWN) ? 4'(1 << n.owner) : 4'b0;
      n.busy  = (n.st != S_IDLE);
      // Display lags the owner's inputs by one cycle and is blank otherwise.
      if (!rst && s.st == S_OWN && n.st == S_OWN) begin
         n.led = led[8*s.owner +: 8];
         n.s1  = s1[9*s.owner +: 9];
         n.s2  = s2[9*s.owner +: 9];
      end else begin
         n.led = 8'hff; n.s1 = 9'h000; n.s2 = 9'h000;
      end
      return n;
   endfunction

   mdl_t m_a = '0;
   mdl_t m_b = '0;

   always @(posedge clk) begin
      m_a <= step(m_a, rst_a, tick_a, req_a, led_a, s1a, s2a, A_GAP, A_HOLD);
      m_b <= step(m_b, rst_b, tick_b, req_b, led_b, s1b, s2b, B_GAP, B_HOLD);
   end

   always @(negedge clk) begin
      if (m_a.valid)
         chk("model_a", 32'({grant_a, busy_a, wl_a, sg1_a, sg2_a}),
             32'({m_a.grant, m_a.busy, m_a.led, m_a.s1, m_a.s2}));
      if (m_b.valid)
         chk("model_b", 32'({grant_b, busy_b, wl_b, sg1_b, sg2_b}),
             32'({m_b.grant, m_b.busy, m_b.led, m_b.s1, m_b.s2}));
   end

   int n, cur, tc;
   int grants[$];
   int ticks_q[$];
   int exp_seq[5] = '{0, 1, 2, 3, 0};

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; tick_a = 1'b0; tick_b = 1'b0;
      req_a = '0; req_b = '0;
      led_a = {8'h81, 8'h42, 8'h3c, 8'h5a};
      s1a   = {9'h101, 9'h0a2, 9'h0c3, 9'h1e4};
      s2a   = {9'h011, 9'h022, 9'h033, 9'h044};
      led_b = {8'h18, 8'h24, 8'h42, 8'h81};
      s1b   = {9'h1f0, 9'h0f1, 9'h0f2, 9'h0f3};
      s2b   = {9'h10f, 9'h01f, 9'h02f, 9'h03f};
      repeat (3) cyc();
      chk("rst_grant", 32'(grant_a), 32'h0);
      chk("rst_busy", 32'(busy_a), 32'h0);
      chk("rst_led", 32'(wl_a), 32'hff);
      chk("rst_seg", 32'({sg1_a, sg2_a}), 32'h0);

      // First grant: t+1 grant, t+2 data
      rst_a = 1'b0; rst_b = 1'b0; req_a = 4'b0001;
      cyc();
      chk("t1_grant", 32'(grant_a), 32'h1);
      chk("t1_busy", 32'(busy_a), 32'h1);
      chk("t1_led_blank", 32'(wl_a), 32'hff);
      chk("pin_model_grant", 32'(m_a.grant), 32'h1);
      cyc();
      chk("t2_led", 32'(wl_a), 32'h5a);
      chk("t2_seg1", 32'(sg1_a), 32'h1e4);
      chk("pin_model_led", 32'(m_a.led), 32'h5a);

      // Preemption after three ticks, full-length gap
      req_a = 4'b0011;
      for (int k = 0; k < 3; k++) begin
         tick_a = 1'b1; cyc(); tick_a = 1'b0;
         if (k < 2) begin
            repeat (3) cyc();
            chk("hold_keep", 32'(grant_a), 32'h1);
         end
      end
      chk("hold_full_own", 32'(grant_a), 32'h1);
      cyc();
      chk("preempt_grant0", 32'(grant_a), 32'h0);
      chk("preempt_busy", 32'(busy_a), 32'h1);
      chk("preempt_led_blank", 32'(wl_a), 32'hff);
      n = 0;
      while (grant_a != 4'b0010 && n < 13000) begin
         cyc(); n++;
         if (n == 6000) begin
            chk("mid_gap_led", 32'(wl_a), 32'hff);
            chk("mid_gap_grant", 32'(grant_a), 32'h0);
         end
      end
      chk("gap_len", 32'(n), 32'd12000);
      chk("grant_to_1", 32'(grant_a), 32'h2);
      cyc();
      chk("own1_led", 32'(wl_a), 32'h3c);

      // Voluntary release coinciding with a tick at hold 1, then idle
      tick_a = 1'b1; cyc(); tick_a = 1'b0; cyc();
      chk("own1_keep", 32'(grant_a), 32'h2);
      tick_a = 1'b1; req_a = 4'b0000; cyc(); tick_a = 1'b0;
      chk("release_grant0", 32'(grant_a), 32'h0);
      chk("release_busy", 32'(busy_a), 32'h1);
      chk("release_led", 32'(wl_a), 32'hff);
      n = 0;
      while (busy_a != 1'b0 && n < 13000) begin cyc(); n++; end
      chk("release_gap_len", 32'(n), 32'd12000);
      chk("idle_grant", 32'(grant_a), 32'h0);
      chk("idle_seg", 32'({wl_a, sg1_a, sg2_a}), 32'({8'hff, 18'h0}));

      // Round-robin rotation on the short-gap instance
      rst_b = 1'b1; cyc(); rst_b = 1'b0; req_b = 4'b1111;
      cur = -1; tc = 0;
      for (int c = 0; c < 400; c++) begin
         if (grants.size() == 5) break;
         tick_b = (c % 4 == 0);
         if (grant_b != 4'b0) begin
            if (cur < 0) begin cur = oh2i(grant_b); grants.push_back(cur); tc = 0; end
            if (tick_b) tc++;
         end else if (cur >= 0) begin
            ticks_q.push_back(tc); cur = -1;
         end
         cyc();
      end
      tick_b = 1'b0;
      chk("rr_grant_count", 32'(grants.size()), 32'd5);
      chk("rr_hold_count", 32'(ticks_q.size()), 32'd4);
      for (int i = 0; i < grants.size() && i < 5; i++) chk("rr_seq", 32'(grants[i]), 32'(exp_seq[i]));
      for (int i = 0; i < ticks_q.size(); i++) chk("rr_hold_ticks", 32'(ticks_q[i]), 32'd3);
      for (int i = 1; i < grants.size(); i++) chk("rr_no_repeat", 32'(grants[i] != grants[i-1]), 32'd1);

      // Reset while requester 2 owns
      n = 0;
      while (grant_b != 4'b0100 && n < 300) begin tick_b = (n % 4 == 0); cyc(); n++; end
      tick_b = 1'b0;
      chk("owner2_reached", 32'(grant_b), 32'h4);
      cyc();
      chk("owner2_led", 32'(wl_b), 32'h24);
      rst_b = 1'b1; cyc();
      chk("midrst_grant", 32'(grant_b), 32'h0);
      chk("midrst_busy", 32'(busy_b), 32'h0);
      chk("midrst_led", 32'(wl_b), 32'hff);
      chk("midrst_seg", 32'({sg1_b, sg2_b}), 32'h0);
      rst_b = 1'b0; cyc();
      chk("postrst_grant", 32'(grant_b), 32'h1);

      // Requester 0 arriving while requester 3 owns at hold 0
      rst_b = 1'b1; req_b = 4'b0000; cyc();
      rst_b = 1'b0; req_b = 4'b1000; cyc();
      chk("own3_grant", 32'(grant_b), 32'h8);
      cyc();
      req_b = 4'b1001; cyc();
`ifdef DISP_ARB_PRIO0_EN
      chk("prio_gap_grant", 32'(grant_b), 32'h0);
      chk("prio_gap_busy", 32'(busy_b), 32'h1);
      n = 0;
      while (grant_b != 4'b0001 && n < 20) begin cyc(); n++; end
      chk("prio_grant0", 32'(grant_b), 32'h1);
`else
      chk("noprio_keep3", 32'(grant_b), 32'h8);
`endif

      // Randomized traffic against the model
      rst_b = 1'b1; cyc(); rst_b = 1'b0;
      for (int c = 0; c < 2500; c++) begin
         if ($urandom_range(3) == 0) req_b = 4'($urandom) | 4'($urandom);
         tick_b = ($urandom_range(4) == 0);
         led_b  = $urandom;
         s1b    = 36'({$urandom, $urandom});
         s2b    = 36'({$urandom, $urandom});
         rst_b  = ($urandom_range(499) == 0);
         cyc();
      end
      rst_b = 1'b0; tick_b = 1'b0;
      repeat (2) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
